// File: rtl/video_frame_meter.sv
// Measures active width/height of a di/de/hs/vs pixel stream, counts frames and flags geometry errors.
// Define VIDEO_FRAME_METER_CHECKSUM_EN to add checksum_o, a per-frame sum of counted pixels.
module video_frame_meter #(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   err_clr_i,
  output logic [CNT_WIDTH-1:0]   meas_w_o,
  output logic [CNT_WIDTH-1:0]   meas_h_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o,
  output logic                   frame_done_o,
  output logic                   err_width_o,
  output logic                   err_geom_o,
  output logic                   ovf_o,
`ifdef VIDEO_FRAME_METER_CHECKSUM_EN
  output logic                   locked_o,
  output logic [31:0]            checksum_o
`else
  output logic                   locked_o
`endif
);

  localparam int unsigned          STAB_W   = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [STAB_W-1:0]    STAB_TGT = STAB_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FRAME, S_LINE} state_e;

  state_e                 state_q, state_d;
  logic [PIXEL_WIDTH-1:0] di_r1_q;
  logic                   de_r1_q, hs_r1_q, vs_r1_q, hs_r2_q, vs_r2_q, in_vld_q;
  logic [CNT_WIDTH-1:0]   xcnt_q, xcnt_d, ycnt_q, ycnt_d, line_w_q, line_w_d;
  logic [CNT_WIDTH-1:0]   meas_w_q, meas_h_q, frame_cnt_q;
  logic                   frame_done_q, err_width_q, err_geom_q, ovf_q, locked_q;
  logic [STAB_W-1:0]      stable_q, stable_d;

  logic hs_rise, hs_fall, vs_rise, vs_fall, pix;
  logic frame_start, frame_end, pix_cnt, width_set, ovf_set, geom_set;
  logic first_frame, geom_mis;

  // Edges come from the first vs second input register; a pixel counts only inside an active line.
  assign hs_rise = hs_r1_q & ~hs_r2_q;
  assign hs_fall = ~hs_r1_q & hs_r2_q;
  assign vs_rise = vs_r1_q & ~vs_r2_q;
  assign vs_fall = ~vs_r1_q & vs_r2_q;
  assign pix     = de_r1_q & ~hs_r1_q & vs_r1_q;

  always_comb begin
    state_d     = state_q;
    xcnt_d      = xcnt_q;
    ycnt_d      = ycnt_q;
    line_w_d    = line_w_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pix_cnt     = 1'b0;
    width_set   = 1'b0;
    ovf_set     = 1'b0;
    case (state_q)
      // in_vld_q keeps the cleared input registers from faking a vs low right after reset
      S_SYNC: begin
        if (in_vld_q && !vs_r1_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (vs_rise) begin
          frame_start = 1'b1;
          ycnt_d      = '0;
          line_w_d    = '0;
          xcnt_d      = '0;
          if (hs_fall) begin
            pix_cnt = pix;
            xcnt_d  = CNT_WIDTH'(pix);
            state_d = S_LINE;
          end else begin
            state_d = S_FRAME;
          end
        end
      end
      S_FRAME: begin
        if (vs_fall) begin
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end else if (hs_fall) begin
          pix_cnt = pix;
          xcnt_d  = CNT_WIDTH'(pix);
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        // A vs fall closes the open line before the frame ends.
        if (hs_rise || vs_fall) begin
          if (xcnt_q != '0) begin
            if (ycnt_q == CNT_MAX) ovf_set = 1'b1;
            else                   ycnt_d  = ycnt_q + CNT_WIDTH'(1);
            if (line_w_q == '0)          line_w_d  = xcnt_q;
            else if (xcnt_q != line_w_q) width_set = 1'b1;
          end
          if (vs_fall) begin
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_FRAME;
          end
        end else if (pix) begin
          pix_cnt = 1'b1;
          if (xcnt_q == CNT_MAX) ovf_set = 1'b1;
          else                   xcnt_d  = xcnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Frame-end geometry comparison against the previously reported frame.
  always_comb begin
    first_frame = (frame_cnt_q == '0);
    geom_mis    = (line_w_d != meas_w_q) || (ycnt_d != meas_h_q);
    stable_d    = stable_q;
    if (frame_end) begin
      if (first_frame || geom_mis)  stable_d = STAB_W'(1);
      else if (stable_q < STAB_TGT) stable_d = stable_q + STAB_W'(1);
    end
    geom_set = frame_end && !first_frame && geom_mis;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      di_r1_q      <= '0;
      de_r1_q      <= 1'b0;
      hs_r1_q      <= 1'b0;
      vs_r1_q      <= 1'b0;
      hs_r2_q      <= 1'b0;
      vs_r2_q      <= 1'b0;
      in_vld_q     <= 1'b0;
      state_q      <= S_SYNC;
      xcnt_q       <= '0;
      ycnt_q       <= '0;
      line_w_q     <= '0;
      meas_w_q     <= '0;
      meas_h_q     <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      err_width_q  <= 1'b0;
      err_geom_q   <= 1'b0;
      ovf_q        <= 1'b0;
      stable_q     <= '0;
      locked_q     <= 1'b0;
    end else begin
      di_r1_q      <= di_i;
      de_r1_q      <= de_i;
      hs_r1_q      <= hs_i;
      vs_r1_q      <= vs_i;
      hs_r2_q      <= hs_r1_q;
      vs_r2_q      <= vs_r1_q;
      in_vld_q     <= 1'b1;
      state_q      <= state_d;
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      line_w_q     <= line_w_d;
      frame_done_q <= frame_end;
      if (frame_end) begin
        meas_w_q    <= line_w_d;
        meas_h_q    <= ycnt_d;
        frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      end
      stable_q    <= stable_d;
      locked_q    <= (stable_d >= STAB_TGT);
      // Flag events override a simultaneous clear.
      err_width_q <= width_set | (err_width_q & ~err_clr_i);
      err_geom_q  <= geom_set  | (err_geom_q  & ~err_clr_i);
      ovf_q       <= ovf_set   | (ovf_q       & ~err_clr_i);
    end
  end

  assign meas_w_o     = meas_w_q;
  assign meas_h_o     = meas_h_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign frame_done_o = frame_done_q;
  assign err_width_o  = err_width_q;
  assign err_geom_o   = err_geom_q;
  assign ovf_o        = ovf_q;
  assign locked_o     = locked_q;

`ifdef VIDEO_FRAME_METER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d, checksum_q;

  // Running sum restarts at frame start and is latched with the measurements.
  always_comb begin
    csum_d = frame_start ? 32'd0 : csum_q;
    if (pix_cnt) csum_d = csum_d + 32'(di_r1_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q     <= '0;
      checksum_q <= '0;
    end else begin
      csum_q <= csum_d;
      if (frame_end) checksum_q <= csum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  logic unused_c;
  assign unused_c = ^{di_r1_q, pix_cnt, frame_start};
`endif

endmodule

// File: tb/tb_video_frame_meter.sv
// Bench for video_frame_meter: a 16-bit and a 4-bit counter instance share one randomized stream
// and are compared against a frame-level reference model.
module tb_video_frame_meter;

  localparam int unsigned PW     = 8;
  localparam int unsigned STABLE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] di;
  logic          de, hs, vs, err_clr;

  logic [15:0] w_a, h_a, fc_a;
  logic [3:0]  w_b, h_b, fc_b;
  logic        done_a, ew_a, eg_a, ovf_a, lk_a;
  logic        done_b, ew_b, eg_b, ovf_b, lk_b;
`ifdef VIDEO_FRAME_METER_CHECKSUM_EN
  logic [31:0] cs_a, cs_b;
`endif

  video_frame_meter #(.PIXEL_WIDTH(PW), .CNT_WIDTH(16), .STABLE_FRAMES(STABLE)) u_dut_a (
    .clk(clk), .rst(rst), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs), .err_clr_i(err_clr),
    .meas_w_o(w_a), .meas_h_o(h_a), .frame_cnt_o(fc_a), .frame_done_o(done_a),
    .err_width_o(ew_a), .err_geom_o(eg_a), .ovf_o(ovf_a), .locked_o(lk_a)
`ifdef VIDEO_FRAME_METER_CHECKSUM_EN
    , .checksum_o(cs_a)
`endif
  );

  video_frame_meter #(.PIXEL_WIDTH(PW), .CNT_WIDTH(4), .STABLE_FRAMES(STABLE)) u_dut_b (
    .clk(clk), .rst(rst), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs), .err_clr_i(err_clr),
    .meas_w_o(w_b), .meas_h_o(h_b), .frame_cnt_o(fc_b), .frame_done_o(done_b),
    .err_width_o(ew_b), .err_geom_o(eg_b), .ovf_o(ovf_b), .locked_o(lk_b)
`ifdef VIDEO_FRAME_METER_CHECKSUM_EN
    , .checksum_o(cs_b)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_n[2];
  int done_ref[2];

  // Reference model state, index 0 = 16-bit instance, 1 = 4-bit instance.
  int          m_max[2];
  int          m_fc[2], m_w[2], m_h[2], m_st[2];
  bit          m_ew[2], m_eg[2], m_ovf[2], m_lk[2];
  int unsigned m_cs;
  int          lines_q[$];
  int          fixed_di;

  always @(negedge clk) begin
    if (done_a) done_n[0]++;
    if (done_b) done_n[1]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_fc[d] = 0; m_w[d] = 0; m_h[d] = 0; m_st[d] = 0;
      m_ew[d] = 1'b0; m_eg[d] = 1'b0; m_ovf[d] = 1'b0; m_lk[d] = 1'b0;
    end
    m_cs = 0;
  endtask

  // Frame-level rules: width = first non-empty line, height = non-empty lines, both saturating.
  task automatic model_frame(input int unsigned sum);
    for (int d = 0; d < 2; d++) begin
      int w, h, s;
      bit first, mis;
      w = 0;
      h = 0;
      foreach (lines_q[i]) begin
        if (lines_q[i] > m_max[d]) m_ovf[d] = 1'b1;
        s = (lines_q[i] > m_max[d]) ? m_max[d] : lines_q[i];
        if (s > 0) begin
          if (h == m_max[d]) m_ovf[d] = 1'b1;
          else               h++;
          if (w == 0)       w = s;
          else if (s != w)  m_ew[d] = 1'b1;
        end
      end
      first = (m_fc[d] == 0);
      mis   = (w != m_w[d]) || (h != m_h[d]);
      if (!first && mis) m_eg[d] = 1'b1;
      if (first || mis)          m_st[d] = 1;
      else if (m_st[d] < STABLE) m_st[d]++;
      m_lk[d] = (m_st[d] >= STABLE);
      m_w[d]  = w;
      m_h[d]  = h;
      m_fc[d] = (m_fc[d] + 1) % (m_max[d] + 1);
      done_ref[d]++;
    end
    m_cs = sum;
  endtask

  task automatic check_all();
    check("meas_w_a", 32'(w_a), 32'(m_w[0]));
    check("meas_h_a", 32'(h_a), 32'(m_h[0]));
    check("fcnt_a",   32'(fc_a), 32'(m_fc[0]));
    check("errw_a",   32'(ew_a), 32'(m_ew[0]));
    check("errg_a",   32'(eg_a), 32'(m_eg[0]));
    check("ovf_a",    32'(ovf_a), 32'(m_ovf[0]));
    check("lock_a",   32'(lk_a), 32'(m_lk[0]));
    check("done_a",   32'(done_n[0]), 32'(done_ref[0]));
    check("meas_w_b", 32'(w_b), 32'(m_w[1]));
    check("meas_h_b", 32'(h_b), 32'(m_h[1]));
    check("fcnt_b",   32'(fc_b), 32'(m_fc[1]));
    check("errw_b",   32'(ew_b), 32'(m_ew[1]));
    check("errg_b",   32'(eg_b), 32'(m_eg[1]));
    check("ovf_b",    32'(ovf_b), 32'(m_ovf[1]));
    check("lock_b",   32'(lk_b), 32'(m_lk[1]));
    check("done_b",   32'(done_n[1]), 32'(done_ref[1]));
`ifdef VIDEO_FRAME_METER_CHECKSUM_EN
    check("csum_a", cs_a, m_cs);
    check("csum_b", cs_b, m_cs);
`endif
  endtask

  task automatic set_lines(input int nl, input int w);
    lines_q.delete();
    repeat (nl) lines_q.push_back(w);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      m_ew[d] = 1'b0; m_eg[d] = 1'b0; m_ovf[d] = 1'b0;
    end
    check_all();
  endtask

  // duty: 0 continuous, 1 alternate, 2 random; smode 1 starts line 0 with vs rise;
  // emode: 0 vs falls with hs rise, 1 vs falls in blanking, 2 vs falls inside the line.
  task automatic run_frame(input int duty, input int smode, input int emode, input int rst_line);
    int unsigned sum;
    bit          discard;
    int          n, ph, tail, hb;
    sum     = 0;
    discard = 1'b0;
    vs = 1'b0;
    hs = 1'b1;
    repeat (3) begin
      de = 1'($urandom_range(0, 1));
      di = PW'($urandom);
      tick();
    end
    de = 1'b0;
    if (smode == 0) begin
      vs = 1'b1;
      tick();
      tick();
    end
    foreach (lines_q[i]) begin
      if (i == rst_line) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        discard = 1'b1;
        model_reset();
        check_all();
      end
      vs = 1'b1;
      hs = 1'b0;
      n  = lines_q[i];
      ph = 0;
      while (n > 0) begin
        case (duty)
          0:       de = 1'b1;
          1:       de = (ph % 2 == 0);
          default: de = ($urandom_range(0, 3) != 0);
        endcase
        ph++;
        di = (fixed_di >= 0) ? PW'(fixed_di) : PW'($urandom);
        if (de) begin
          sum += 32'(di);
          n--;
        end
        tick();
      end
      de   = 1'b0;
      tail = (lines_q[i] == 0) ? 1 : $urandom_range(0, 1);
      repeat (tail) tick();
      if (i == int'(lines_q.size()) - 1) begin
        case (emode)
          0: begin
            hs = 1'b1;
            vs = 1'b0;
            tick();
          end
          1: begin
            hs = 1'b1;
            repeat (2) begin
              de = 1'($urandom_range(0, 1));
              tick();
            end
            vs = 1'b0;
            de = 1'b0;
            tick();
          end
          default: begin
            vs = 1'b0;
            de = 1'($urandom_range(0, 1));
            tick();
            tick();
            hs = 1'b1;
            de = 1'b0;
            tick();
          end
        endcase
      end else begin
        hs = 1'b1;
        hb = $urandom_range(1, 3);
        repeat (hb) begin
          de = 1'($urandom_range(0, 1));
          di = PW'($urandom);
          tick();
        end
        de = 1'b0;
      end
    end
    vs = 1'b0;
    hs = 1'b1;
    de = 1'b0;
    repeat (4) tick();
    if (!discard) model_frame(sum);
    check_all();
  endtask

  initial begin
    int nl, base, rl;
    rst      = 1'b1;
    di       = '0;
    de       = 1'b0;
    hs       = 1'b1;
    vs       = 1'b0;
    err_clr  = 1'b0;
    fixed_di = -1;
    m_max[0] = 65535;
    m_max[1] = 15;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    check_all();
    tick();

    set_lines(24, 24);
    run_frame(0, 0, 0, -1);
    run_frame(1, 0, 0, -1);
    run_frame(1, 1, 1, -1);

    set_lines(24, 24);
    lines_q[4] = 23;
    run_frame(0, 0, 0, -1);
    clear_errs();

    set_lines(24, 24);
    run_frame(0, 0, 1, -1);
    set_lines(20, 24);
    run_frame(0, 0, 2, -1);
    clear_errs();

    set_lines(24, 24);
    run_frame(0, 0, 0, 10);
    run_frame(0, 0, 0, -1);

    set_lines(3, 0);
    run_frame(0, 0, 0, -1);

    fixed_di = 16;
    set_lines(4, 4);
    run_frame(0, 0, 0, -1);
    fixed_di = -1;

    nl   = 6;
    base = 10;
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        nl   = $urandom_range(1, 20);
        base = $urandom_range(1, 20);
      end
      lines_q.delete();
      for (int l = 0; l < nl; l++)
        lines_q.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : base);
      rl = ($urandom_range(0, 9) == 0 && nl > 2) ? 1 : -1;
      run_frame($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 2), rl);
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
